// File: rtl/reg_context_mover_pkg.sv
// Shared definitions for the register-file context save/restore sequencer.
package reg_context_mover_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/reg_context_mover.sv
// Context mover: walks registers FIRST_REG..LAST_REG through the register
// file read port into a valid/ready stream (save), or writes an incoming
// valid/ready stream back into the same range through the write port (restore).
module reg_context_mover #(
  parameter int DATA_W    = reg_context_mover_pkg::DATA_W,
  parameter int ADDR_W    = reg_context_mover_pkg::ADDR_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_src_reg,
  input  logic [DATA_W-1:0] rf_src_data,
  output logic [ADDR_W-1:0] rf_dst_reg,
  output logic [DATA_W-1:0] rf_dst_data,
  output logic              rf_write,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);
  import reg_context_mover_pkg::*;

  localparam logic [ADDR_W-1:0] LP_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(LAST_REG);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  // Set once the LAST_REG word has been loaded into the output register, so
  // idx can stop at LAST_REG instead of running one past it.
  logic                r_sent_last;
  logic                w_advance;
  logic                w_in_restore;

  // Output slot can take a new word when empty or when its word is being taken.
  assign w_advance    = !r_out_valid || out_ready;
  // Abort cuts the restore handshake and write strobe in the same cycle.
  assign w_in_restore = (r_state == ST_RESTORE) && !abort;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (save_req)         w_state_nxt = ST_SAVE;
          else if (restore_req) w_state_nxt = ST_RESTORE;
        end
        ST_SAVE: begin
          if (w_advance && r_sent_last) w_state_nxt = ST_DONE;
        end
        ST_RESTORE: begin
          if (in_valid && (r_idx == LP_LAST)) w_state_nxt = ST_DONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Index counter and registered save-stream output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sent_last <= 1'b0;
    end else if (abort) begin
      r_out_valid <= 1'b0;
      r_sent_last <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (save_req || restore_req) begin
            r_idx       <= LP_FIRST;
            r_sent_last <= 1'b0;
          end
        end
        ST_SAVE: begin
          if (w_advance) begin
            if (!r_sent_last) begin
              r_out_data  <= rf_src_data;
              r_out_valid <= 1'b1;
              if (r_idx == LP_LAST) r_sent_last <= 1'b1;
              else                  r_idx       <= r_idx + 1'b1;
            end else begin
              r_out_valid <= 1'b0;
            end
          end
        end
        ST_RESTORE: begin
          if (in_valid && (r_idx != LP_LAST)) r_idx <= r_idx + 1'b1;
        end
        default: r_sent_last <= 1'b0;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign rf_src_reg  = (r_state == ST_SAVE) ? r_idx : '0;
  assign rf_dst_reg  = w_in_restore ? r_idx : '0;
  assign rf_dst_data = w_in_restore ? in_data : '0;
  assign rf_write    = w_in_restore && in_valid;
  assign in_ready    = w_in_restore;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_reg_context_mover.sv
// Self-checking bench for reg_context_mover: a 16-entry register file model
// sits beside the default build, and a FIRST_REG=1 build reads from a ROM.
module tb_reg_context_mover;

  logic        clk = 1'b0;
  logic        rst;
  logic        save_req, restore_req, abort;
  logic        busy, done;
  logic [3:0]  rf_src_reg, rf_dst_reg;
  logic [15:0] rf_src_data, rf_dst_data;
  logic        rf_write;
  logic [15:0] out_data;
  logic        out_valid, out_ready;
  logic [15:0] in_data;
  logic        in_valid, in_ready;

  logic        save_req_1, busy_1, done_1;
  logic [3:0]  rf_src_reg_1, rf_dst_reg_1;
  logic [15:0] rf_src_data_1, rf_dst_data_1, out_data_1;
  logic        rf_write_1, out_valid_1, out_ready_1, in_ready_1;

  logic [15:0] rf [16];
  logic        tb_wr;
  logic [3:0]  tb_addr;
  logic [15:0] tb_data;

  logic [15:0] exp_q [$];
  logic [19:0] expw_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  reg_context_mover u_dut (
    .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
    .abort(abort), .busy(busy), .done(done), .rf_src_reg(rf_src_reg),
    .rf_src_data(rf_src_data), .rf_dst_reg(rf_dst_reg), .rf_dst_data(rf_dst_data),
    .rf_write(rf_write), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready)
  );

  reg_context_mover #(.FIRST_REG(1), .LAST_REG(15)) u_dut1 (
    .clk(clk), .rst(rst), .save_req(save_req_1), .restore_req(1'b0),
    .abort(1'b0), .busy(busy_1), .done(done_1), .rf_src_reg(rf_src_reg_1),
    .rf_src_data(rf_src_data_1), .rf_dst_reg(rf_dst_reg_1),
    .rf_dst_data(rf_dst_data_1), .rf_write(rf_write_1), .out_data(out_data_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .in_data(16'h0000),
    .in_valid(1'b0), .in_ready(in_ready_1)
  );

  // Register file model: DUT write port has priority over bench preload.
  always @(posedge clk) begin
    if (rf_write)   rf[rf_dst_reg] <= rf_dst_data;
    else if (tb_wr) rf[tb_addr]    <= tb_data;
  end
  assign rf_src_data   = rf[rf_src_reg];
  assign rf_src_data_1 = 16'h0100 + {12'h000, rf_src_reg_1};

  task automatic test_reset();
    rst = 1'b0; save_req = 0; restore_req = 0; abort = 0; out_ready = 0;
    in_valid = 0; in_data = 16'h0; tb_wr = 0; tb_addr = 0; tb_data = 0;
    save_req_1 = 0; out_ready_1 = 0;
    #2;
    checks++;
    if ({busy, done, out_valid, in_ready, rf_write} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, out_valid, in_ready, rf_write});
    end
    checks++;
    if ({out_data, rf_src_reg, rf_dst_reg, rf_dst_data} !== 40'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {out_data, rf_src_reg, rf_dst_reg, rf_dst_data});
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) begin
      tb_wr = 1; tb_addr = 4'(i); tb_data = 16'h0100 + 16'(i);
      @(posedge clk); #1;
    end
    tb_wr = 0;
  endtask

  task automatic test_save_full();
    int nw = 0; bit got_done = 0; logic [15:0] w;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h0100 + 16'(i));
    save_req = 1; out_ready = 1;
    @(posedge clk); #1 save_req = 0;
    for (int m = 0; m < 60 && !got_done; m++) begin
      @(negedge clk);
      if (m == 0) begin
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
          errors++; $display("FAIL save_start busy=%b out_valid=%b want 1/0", busy, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_data !== w || m != nw + 1) begin
          errors++; $display("FAIL save_word got %h at cyc %0d want %h at cyc %0d", out_data, m, w, nw + 1);
        end
        nw++;
      end
      if (done) begin
        got_done = 1; checks++;
        if (m != 17) begin errors++; $display("FAIL save_done_cyc got %0d want 17", m); end
      end
      if (!got_done) begin @(posedge clk); #1; end
    end
    checks++;
    if (!got_done || nw != 16) begin
      errors++; $display("FAIL save_count got %0d done=%0d want 16 done=1", nw, got_done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL save_end busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_save_stall();
    int nw = 0; bit got_done = 0; bit prev_stall = 0; logic [15:0] prev_data = 0; logic [15:0] w;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h0100 + 16'(i));
    save_req = 1; out_ready = 1;
    @(posedge clk); #1 save_req = 0;
    for (int m = 0; m < 200 && !got_done; m++) begin
      out_ready = (m % 4 == 0) || (m % 4 == 3);
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL stall_hold got %b/%h want 1/%h", out_valid, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        checks++;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_data !== w) begin errors++; $display("FAIL stall_word got %h want %h", out_data, w); end
        nw++;
      end
      if (done) got_done = 1;
      else begin @(posedge clk); #1; end
    end
    out_ready = 0;
    checks++;
    if (!got_done || nw != 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_count got %0d done=%0d want 16 done=1", nw, got_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_restore();
    int sent = 0; bit got_done = 0; logic [19:0] w;
    expw_q.delete();
    for (int i = 0; i < 16; i++) expw_q.push_back({4'(i), 16'hA000 + 16'(i)});
    restore_req = 1;
    @(posedge clk); #1 restore_req = 0;
    for (int m = 0; m < 200 && !got_done; m++) begin
      in_valid = (m % 3 != 2) && (sent < 16);
      in_data  = 16'hA000 + 16'(sent);
      @(negedge clk);
      checks++;
      if (rf_write !== in_valid) begin
        errors++; $display("FAIL restore_wr got %b want %b", rf_write, in_valid);
      end
      if (rf_write) begin
        checks++;
        w = (expw_q.size() > 0) ? expw_q.pop_front() : 20'hxxxxx;
        if ({rf_dst_reg, rf_dst_data} !== w) begin
          errors++; $display("FAIL restore_word got %h want %h", {rf_dst_reg, rf_dst_data}, w);
        end
      end
      if (in_valid && in_ready) sent++;
      if (done) got_done = 1;
      else begin @(posedge clk); #1; end
    end
    in_valid = 0;
    checks++;
    if (!got_done || sent != 16) begin
      errors++; $display("FAIL restore_count got %0d done=%0d want 16 done=1", sent, got_done);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf[i] !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL restore_rf R%0d got %h want %h", i, rf[i], 16'hA000 + 16'(i));
      end
    end
  endtask

  task automatic test_both_req();
    int nw = 0; bit got_done = 0; logic [15:0] w;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'hA000 + 16'(i));
    save_req = 1; restore_req = 1; out_ready = 1;
    @(posedge clk); #1 save_req = 0; restore_req = 0;
    for (int m = 0; m < 60 && !got_done; m++) begin
      restore_req = (m == 3);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || rf_write !== 1'b0) begin
        errors++; $display("FAIL both_restore_leak in_ready=%b rf_write=%b want 0/0", in_ready, rf_write);
      end
      if (out_valid && out_ready) begin
        checks++;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_data !== w) begin errors++; $display("FAIL both_word got %h want %h", out_data, w); end
        nw++;
      end
      if (done) got_done = 1;
      else begin @(posedge clk); #1; end
    end
    restore_req = 0;
    checks++;
    if (!got_done || nw != 16) begin
      errors++; $display("FAIL both_count got %0d done=%0d want 16 done=1", nw, got_done);
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL both_queued busy=%b in_ready=%b want 0/0", busy, in_ready);
    end
  endtask

  task automatic test_abort();
    int nw = 0; bit got_done = 0; bit saw_done = 0; logic [15:0] w;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'hA000 + 16'(i));
    save_req = 1; out_ready = 1;
    @(posedge clk); #1 save_req = 0;
    for (int m = 0; m < 40 && nw < 5; m++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        w = exp_q.pop_front();
        if (out_data !== w) begin errors++; $display("FAIL abort_word got %h want %h", out_data, w); end
        nw++;
      end
      @(posedge clk); #1;
    end
    abort = 1; out_ready = 0;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_stop out_valid=%b busy=%b done=%b want 0/0/0", out_valid, busy, done);
    end
    for (int m = 0; m < 4; m++) begin @(negedge clk); if (done) saw_done = 1; end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_done got 1 want 0"); end
    @(posedge clk); #1;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'hA000 + 16'(i));
    nw = 0;
    save_req = 1; out_ready = 1;
    @(posedge clk); #1 save_req = 0;
    for (int m = 0; m < 60 && !got_done; m++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_data !== w) begin errors++; $display("FAIL resave_word got %h want %h", out_data, w); end
        nw++;
      end
      if (done) got_done = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!got_done || nw != 16) begin
      errors++; $display("FAIL resave_count got %0d done=%0d want 16 done=1", nw, got_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int wr = 0;
    restore_req = 1;
    @(posedge clk); #1 restore_req = 0;
    for (int m = 0; m < 40 && wr < 7; m++) begin
      in_valid = 1; in_data = 16'hB000 + 16'(wr);
      @(negedge clk);
      if (rf_write) wr++;
      @(posedge clk); #1;
    end
    rst = 0; in_valid = 0;
    #1;
    checks++;
    if ({busy, done, out_valid, in_ready, rf_write} !== 5'b0 ||
        {out_data, rf_src_reg, rf_dst_reg, rf_dst_data} !== 40'h0) begin
      errors++; $display("FAIL midreset_outputs got %b %h want 0", {busy, done, out_valid, in_ready, rf_write},
                         {out_data, rf_src_reg, rf_dst_reg, rf_dst_data});
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rf[i] !== ((i < 7) ? 16'hB000 + 16'(i) : 16'hA000 + 16'(i))) begin
        errors++; $display("FAIL midreset_rf R%0d got %h", i, rf[i]);
      end
    end
  endtask

  task automatic test_first_reg1();
    int nw = 0; bit got_done = 0; logic [15:0] w;
    exp_q.delete();
    for (int i = 1; i < 16; i++) exp_q.push_back(16'h0100 + 16'(i));
    save_req_1 = 1; out_ready_1 = 1;
    @(posedge clk); #1 save_req_1 = 0;
    for (int m = 0; m < 60 && !got_done; m++) begin
      @(negedge clk);
      checks++;
      if ({rf_write_1, in_ready_1, rf_dst_reg_1, rf_dst_data_1} !== 22'h0) begin
        errors++; $display("FAIL first1_wrport got %h want 0", {rf_write_1, in_ready_1, rf_dst_reg_1, rf_dst_data_1});
      end
      if (out_valid_1 && out_ready_1) begin
        checks++;
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        if (out_data_1 !== w) begin errors++; $display("FAIL first1_word got %h want %h", out_data_1, w); end
        nw++;
      end
      if (done_1) begin
        got_done = 1; checks++;
        if (m != 16) begin errors++; $display("FAIL first1_done_cyc got %0d want 16", m); end
      end
      if (!got_done) begin @(posedge clk); #1; end
    end
    checks++;
    if (!got_done || nw != 15) begin
      errors++; $display("FAIL first1_count got %0d done=%0d want 15 done=1", nw, got_done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_1 !== 1'b0) begin errors++; $display("FAIL first1_busy got %b want 0", busy_1); end
  endtask

  initial begin
    test_reset();
    preload();
    test_save_full();
    test_save_stall();
    test_restore();
    test_both_req();
    test_abort();
    test_reset_mid();
    test_first_reg1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_context_mover.md
# reg_context_mover

Save/restore sequencer that acts as the initiator on the register file's read and write ports. On a save request it walks the registers through the read port and streams their contents out over a valid/ready interface. On a restore request it accepts a valid/ready stream and writes each word back into consecutive registers through the write port. It sits beside the register file and is used for context switch, debug dump and test preload.

## Interface
Parameters:
- DATA_W, 16, register width
- ADDR_W, 4, register index width
- FIRST_REG, 0, first register index moved (1 skips R0)
- LAST_REG, 15, last register index moved (must be ≥ FIRST_REG)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset
- save_req  input  1  start save; sampled in IDLE only
- restore_req  input  1  start restore; sampled in IDLE only
- abort  input  1  return to IDLE on the next edge; no done pulse
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last word moves
- rf_src_reg  output  ADDR_W  read index to register file
- rf_src_data  input  DATA_W  combinational read data for rf_src_reg
- rf_dst_reg  output  ADDR_W  write index
- rf_dst_data  output  DATA_W  write data
- rf_write  output  1  write enable; the register file writes on the rising edge
- out_data  output  DATA_W  save stream data (registered)
- out_valid  output  1  save stream valid (registered)
- out_ready  input  1  save stream ready
- in_data  input  DATA_W  restore stream data
- in_valid  input  1  restore stream valid
- in_ready  output  1  restore stream ready

## Operation
States:
- IDLE
  - save_req → SAVE; restore_req → RESTORE.
  - If both are high, save wins.
  - idx loads FIRST_REG on either transition.
- SAVE
  - rf_src_reg = idx.
  - On each edge where out_valid=0, or out_valid=1 with out_ready=1: if words remain, out_data ← rf_src_data, out_valid ← 1, idx++.
  - When the last word (LAST_REG) is accepted and no words remain: out_valid ← 0, go to DONE.
  - rf_write = 0 throughout.
- RESTORE
  - in_ready = 1.
  - rf_write = in_valid, combinational; rf_dst_reg = idx; rf_dst_data = in_data.
  - Each edge with in_valid=1: idx++.
  - After the write to LAST_REG, go to DONE.
- DONE
  - done = 1 for one cycle; return to IDLE.
- abort
  - Any state → IDLE on the next edge.
  - out_valid drops, in_ready drops, no further writes, done stays 0.
  - abort has priority over all other transitions.

Rules:
- Requests arriving in any non-IDLE state are ignored, not queued.
- out_data is held stable while out_valid=1 and out_ready=0.
- in_ready is 0 and rf_write is 0 outside RESTORE.
- idx never exceeds LAST_REG and does not wrap.
- Word count moved per operation = LAST_REG − FIRST_REG + 1.

## Timing
- Reset values, asserted immediately on rst low, including mid-operation:
  - state = IDLE
  - busy, done, out_valid, in_ready, rf_write = 0
  - out_data, rf_src_reg, rf_dst_reg, rf_dst_data, idx = 0
- Save latency: save_req sampled at edge k; first out_valid at edge k+1.
- Save throughput: one word per cycle while out_ready is held high.
- Full save with out_ready held high: done is high in the cycle after edge k+N+1, where N = word count.
- Restore: the first word can be accepted in the cycle after restore_req is sampled. The write lands on the same edge that accepts the word.
- busy rises the edge after the request and falls when DONE exits.

## Structure
- Shared CPU package holds:
  - DATA_W and ADDR_W constants
  - state enum (IDLE, SAVE, RESTORE, DONE)
- No sub-modules. One state register, one idx counter and the output data/valid register.
- Top-level integration muxes rf_src_reg, rf_dst_reg, rf_dst_data and rf_write between the pipeline and this block using busy.

## Test plan
- Reset, then preload R0–R15 with 0x0100+i; pulse save_req; hold out_ready=1 → 16 words 0x0100..0x010F on consecutive cycles, then one done pulse and busy=0.
- Save with out_ready toggled 1,0,0,1,… → no word dropped or duplicated; out_data holds stable while stalled.
- Restore 16 words 0xA000+i with in_valid gaps every third cycle → the register file reads back 0xA000+i for every i; rf_write is never high without in_valid.
- save_req and restore_req high together in IDLE → SAVE is entered; restore_req pulsed mid-save → ignored.
- abort after 5 words → out_valid=0 next cycle, no done pulse, idx reset on the next save_req; a following save streams from FIRST_REG.
- rst low mid-restore after 7 writes → all outputs 0 immediately, R7–R15 unchanged; FIRST_REG=1 build skips R0 (15 words).
